// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus carry flop, LSB first, start/busy/done framed.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf_o.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | one operand bit per cycle
    // DONE  | result valid, one-cycle done pulse
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, psum_q, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             c_q, cout_q;
    logic             s_bit, c_nxt, last_bit, accept;
    logic [WIDTH-1:0] psum_nxt;

    assign s_bit    = a_q[0] ^ b_q[0] ^ c_q;
    assign c_nxt    = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
    assign psum_nxt = {s_bit, psum_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    assign accept   = start_i && (state_q != RUN);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = start_i ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            RUN:     busy_o = 1'b1;
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    // Sum/Cout are hold registers: they only change on the last RUN bit.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= 1'b0;
            psum_q <= '0;
            cnt_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_q    <= a_i;
            b_q    <= b_i;
            c_q    <= cin_i;
            psum_q <= '0;
            cnt_q  <= '0;
        end else if (state_q == RUN) begin
            a_q    <= a_q >> 1;
            b_q    <= b_q >> 1;
            c_q    <= c_nxt;
            psum_q <= psum_nxt;
            cnt_q  <= cnt_q + CW'(1);
            if (last_bit) begin
                sum_q  <= psum_nxt;
                cout_q <= c_nxt;
            end
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // On the last bit c_q is the carry into the MSB and c_nxt the carry out of it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovf_q <= 1'b0;
        end else if (!accept && state_q == RUN && last_bit) begin
            ovf_q <= c_q ^ c_nxt;
        end
    end

    assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8); ovf checks follow SERIAL_ADDER_OVF_EN.
module tb_serial_adder;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] a_i = '0;
    logic [7:0] b_i = '0;
    logic       cin_i = 1'b0;
    logic       busy_o, done_o, cout_o;
    logic [7:0] sum_o;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf_o;
`endif

    int pass_cnt = 0;
    int total = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .cin_i   (cin_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .sum_o   (sum_o),
        .cout_o  (cout_o)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf_o   (ovf_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Pulses start for one cycle, then waits (bounded) for done.
    // lat = clock edges from the accepting edge to the edge raising done (-1 on timeout).
    // Returns positioned at the negedge where done is first seen high.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          output int lat, output int busy_cnt);
        @(negedge clk_i);
        a_i = a; b_i = b; cin_i = cin; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        a_i = 8'h00; b_i = 8'h00; cin_i = 1'b0;
        lat = -1;
        busy_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            if (done_o) begin
                lat = i - 1;
                break;
            end
            if (busy_o) busy_cnt++;
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        #12;
        total++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || sum_o !== 8'h00 || cout_o !== 1'b0)
            $display("FAIL reset_outputs: busy=%b done=%b sum=%h cout=%b, want 0 0 00 0",
                     busy_o, done_o, sum_o, cout_o);
        else pass_cnt++;
`ifdef SERIAL_ADDER_OVF_EN
        total++;
        if (ovf_o !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf_o);
        else pass_cnt++;
`endif
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic test_zero();
        int lat, bc, extra;
        run_op(8'h00, 8'h00, 1'b0, lat, bc);
        total++;
        if (lat !== 8) $display("FAIL zero_latency: got %0d want 8", lat);
        else pass_cnt++;
        total++;
        if (bc !== 8) $display("FAIL zero_busy_cycles: got %0d want 8", bc);
        else pass_cnt++;
        total++;
        if (sum_o !== 8'h00 || cout_o !== 1'b0)
            $display("FAIL zero_result: got sum=%h cout=%b want 00 0", sum_o, cout_o);
        else pass_cnt++;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            if (done_o) extra++;
        end
        total++;
        if (extra !== 0) $display("FAIL zero_single_done: got %0d extra pulses want 0", extra);
        else pass_cnt++;
    endtask

    task automatic test_carry();
        int lat, bc;
        run_op(8'hFF, 8'h01, 1'b0, lat, bc);
        total++;
        if (lat !== 8 || sum_o !== 8'h00 || cout_o !== 1'b1)
            $display("FAIL carry_ff_01: got lat=%0d sum=%h cout=%b want 8 00 1", lat, sum_o, cout_o);
        else pass_cnt++;
`ifdef SERIAL_ADDER_OVF_EN
        total++;
        if (ovf_o !== 1'b0) $display("FAIL carry_ff_01_ovf: got %b want 0", ovf_o);
        else pass_cnt++;
`endif
        run_op(8'h80, 8'h80, 1'b1, lat, bc);
        total++;
        if (lat !== 8 || sum_o !== 8'h01 || cout_o !== 1'b1)
            $display("FAIL carry_80_80_1: got lat=%0d sum=%h cout=%b want 8 01 1", lat, sum_o, cout_o);
        else pass_cnt++;
`ifdef SERIAL_ADDER_OVF_EN
        total++;
        if (ovf_o !== 1'b1) $display("FAIL carry_80_80_1_ovf: got %b want 1", ovf_o);
        else pass_cnt++;
`endif
    endtask

    task automatic test_overflow();
        int lat, bc;
        run_op(8'h7F, 8'h01, 1'b0, lat, bc);
        total++;
        if (lat !== 8 || sum_o !== 8'h80 || cout_o !== 1'b0)
            $display("FAIL ovf_7f_01: got lat=%0d sum=%h cout=%b want 8 80 0", lat, sum_o, cout_o);
        else pass_cnt++;
`ifdef SERIAL_ADDER_OVF_EN
        total++;
        if (ovf_o !== 1'b1) $display("FAIL ovf_7f_01_flag: got %b want 1", ovf_o);
        else pass_cnt++;
`endif
    endtask

    task automatic test_round_trip();
        logic [7:0] vals [4] = '{8'h00, 8'h5A, 8'hA5, 8'hFF};
        logic [7:0] diff, bb;
        int lat, bc;
        for (int ia = 0; ia < 4; ia++)
            for (int ib = 0; ib < 4; ib++)
                for (int bin = 0; bin < 2; bin++) begin
                    diff = vals[ia] - vals[ib] - 8'(bin);
                    bb   = vals[ib] + 8'(bin);
                    run_op(diff, bb, 1'b0, lat, bc);
                    total++;
                    if (lat !== 8 || sum_o !== vals[ia])
                        $display("FAIL round_trip A=%h B=%h Bin=%0d: got lat=%0d sum=%h want 8 %h",
                                 vals[ia], vals[ib], bin, lat, sum_o, vals[ia]);
                    else pass_cnt++;
                end
    endtask

    task automatic test_ignored_start();
        int pulses, first_at;
        logic [7:0] first_sum;
        @(negedge clk_i);
        a_i = 8'h10; b_i = 8'h20; cin_i = 1'b0; start_i = 1'b1;
        pulses = 0;
        first_at = -1;
        first_sum = 8'hxx;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk_i);
            start_i = (i == 3);
            if (i == 3) a_i = 8'hFF;
            if (done_o) begin
                pulses++;
                if (first_at < 0) begin
                    first_at = i - 1;
                    first_sum = sum_o;
                end
            end
        end
        start_i = 1'b0;
        total++;
        if (pulses !== 1) $display("FAIL ignored_start_pulses: got %0d want 1", pulses);
        else pass_cnt++;
        total++;
        if (first_at !== 8 || first_sum !== 8'h30)
            $display("FAIL ignored_start_result: got lat=%0d sum=%h want 8 30", first_at, first_sum);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat, bc, gap;
        run_op(8'h05, 8'h06, 1'b0, lat, bc);
        total++;
        if (lat !== 8 || sum_o !== 8'h0B)
            $display("FAIL b2b_first: got lat=%0d sum=%h want 8 0b", lat, sum_o);
        else pass_cnt++;
        a_i = 8'h01; b_i = 8'h02; cin_i = 1'b0; start_i = 1'b1;
        gap = -1;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (done_o) begin
                gap = j;
                break;
            end
        end
        total++;
        if (gap !== 9) $display("FAIL b2b_gap: got %0d want 9", gap);
        else pass_cnt++;
        total++;
        if (sum_o !== 8'h03 || cout_o !== 1'b0)
            $display("FAIL b2b_second: got sum=%h cout=%b want 03 0", sum_o, cout_o);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int pulses, lat, bc;
        @(negedge clk_i);
        a_i = 8'h33; b_i = 8'h44; cin_i = 1'b0; start_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk_i);
            start_i = 1'b0;
        end
        total++;
        if (busy_o !== 1'b1 || sum_o !== 8'h03)
            $display("FAIL mid_run_state: got busy=%b sum=%h want 1 03", busy_o, sum_o);
        else pass_cnt++;
        rst_n_i = 1'b0;
        #1;
        total++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || sum_o !== 8'h00 || cout_o !== 1'b0)
            $display("FAIL mid_reset_outputs: got busy=%b done=%b sum=%h cout=%b want 0 0 00 0",
                     busy_o, done_o, sum_o, cout_o);
        else pass_cnt++;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        rst_n_i = 1'b1;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk_i);
            if (done_o || busy_o) pulses++;
        end
        total++;
        if (pulses !== 0) $display("FAIL mid_reset_no_activity: got %0d busy/done cycles want 0", pulses);
        else pass_cnt++;
        run_op(8'h01, 8'h01, 1'b1, lat, bc);
        total++;
        if (lat !== 8 || sum_o !== 8'h03 || cout_o !== 1'b0)
            $display("FAIL post_reset_op: got lat=%0d sum=%h cout=%b want 8 03 0", lat, sum_o, cout_o);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_carry();
        test_overflow();
        test_round_trip();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
